// File: rtl/rotatix_add_arbiter.sv
// rotatix_add_arbiter: two requesters share one WIDTH-bit adder through a
// round-robin arbiter. The single result register drains through a
// valid/ready handshake, and it can sustain one result per cycle.
// Optional feature: define ROTATIX_ADD_SAT_EN to clamp an overflowing sum to
// all-ones. res_carry still reports the overflow when the clamp is enabled.
module rotatix_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic             last_q, last_d;   // 1: requester 1 was granted last

    logic             accept_en;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   add_full;

`ifdef ROTATIX_ADD_SAT_EN
    // Clamp to all-ones when the addition carries out of WIDTH bits.
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] full);
        return full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
    endfunction
`endif

    // Arbitration: a lone requester wins outright, and a contested cycle goes
    // to whichever requester was not granted last. Reset masks both readys.
    always_comb begin
        accept_en  = (state_q == EMPTY) || res_ready;
        gnt0       = accept_en && req0_valid && (!req1_valid || last_q);
        gnt1       = accept_en && req1_valid && (!req0_valid || !last_q);
        req0_ready = rst_n && gnt0;
        req1_ready = rst_n && gnt1;
    end

    // Shared adder fed by the granted requester's operands.
    always_comb begin
        op_a     = gnt1 ? req1_a : req0_a;
        op_b     = gnt1 ? req1_b : req0_b;
        add_full = {1'b0, op_a} + {1'b0, op_b};
    end

    // Next-state logic: a grant loads the result register (even while the old
    // result is draining), and a handshake with no grant empties it.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        last_d  = last_q;
        if (gnt0 || gnt1) begin
            state_d = FULL;
`ifdef ROTATIX_ADD_SAT_EN
            sum_d   = sat_sum(add_full);
`else
            sum_d   = add_full[WIDTH-1:0];
`endif
            carry_d = add_full[WIDTH];
            id_d    = gnt1;
            last_d  = gnt1;
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    // State and result registers. The round-robin pointer resets so that
    // requester 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;

endmodule
